// File: rtl/rpn_engine_if.sv
// Command handshake between the input interface and the RPN engine.
interface rpn_engine_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ack;
   logic [3:0]       in_cmd;
   logic [WIDTH-1:0] in_data;

   // Command source (input interface / testbench)
   modport master (output in_valid, output in_cmd, output in_data, input in_ack);
   // Command sink (engine)
   modport slave  (input in_valid, input in_cmd, input in_data, output in_ack);
endinterface

// File: rtl/rpn_engine.sv
// Reverse-Polish evaluation core: internal stack, single-cycle ALU ops,
// iterative shift-add multiplier and sticky error flags.
module rpn_engine #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   localparam int DW    = $clog2(DEPTH+1)
) (
   input  logic             Clock,
   input  logic             Reset,
   rpn_engine_if.slave      bus,
   output logic [WIDTH-1:0] top_data,
   output logic [DW-1:0]    depth,
   output logic             done,
   output logic             err_ovf,
   output logic             err_unf,
   output logic             err_ill
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_PUSH  = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_MUL   = 4'd4,
      OP_DUP   = 4'd5,
      OP_SWAP  = 4'd6,
      OP_DROP  = 4'd7,
      OP_CLEAR = 4'd8
   } op_e;

   typedef enum logic {S_IDLE, S_MUL} state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
   logic [WIDTH-1:0] stk_q [DEPTH];
   logic [WIDTH-1:0] stk_d [DEPTH];
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Entry 0 is the bottom of the stack; TOS lives at depth-1, NOS at depth-2.
   logic [AW-1:0]    tos_idx, nos_idx, push_idx;
   logic [WIDTH-1:0] tos, nos, acc_step;
   logic             full, has1, has2;

   assign tos_idx  = AW'(depth_q - DW'(1));
   assign nos_idx  = AW'(depth_q - DW'(2));
   assign push_idx = AW'(depth_q);
   assign tos      = stk_q[tos_idx];
   assign nos      = stk_q[nos_idx];
   assign full     = (depth_q == DW'(DEPTH));
   assign has1     = (depth_q >= DW'(1));
   assign has2     = (depth_q >= DW'(2));
   assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

   assign bus.in_ack = (state_q == S_IDLE);
   assign top_data   = top_q;
   assign depth      = depth_q;
   assign done       = done_q;
   assign err_ovf    = ovf_q;
   assign err_unf    = unf_q;
   assign err_ill    = ill_q;

   // Next-state: command decode in IDLE, one multiplier bit per cycle in MUL.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      depth_d  = depth_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      ill_d    = ill_q;
      stk_d    = stk_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               done_d = 1'b1;
               case (bus.in_cmd)
                  OP_NOP: ;
                  OP_PUSH: begin
                     if (full) ovf_d = 1'b1;
                     else begin
                        stk_d[push_idx] = bus.in_data;
                        depth_d         = depth_q + DW'(1);
                     end
                  end
                  OP_ADD, OP_SUB: begin
                     if (!has2) unf_d = 1'b1;
                     else begin
                        stk_d[nos_idx] = (bus.in_cmd == OP_ADD) ? nos + tos : nos - tos;
                        depth_d        = depth_q - DW'(1);
                     end
                  end
                  OP_MUL: begin
                     if (!has2) unf_d = 1'b1;
                     else begin
                        done_d   = 1'b0;
                        state_d  = S_MUL;
                        mcand_d  = nos;
                        mplier_d = tos;
                        acc_d    = '0;
                        cnt_d    = '0;
                     end
                  end
                  OP_DUP: begin
                     if (!has1)     unf_d = 1'b1;
                     else if (full) ovf_d = 1'b1;
                     else begin
                        stk_d[push_idx] = tos;
                        depth_d         = depth_q + DW'(1);
                     end
                  end
                  OP_SWAP: begin
                     if (!has2) unf_d = 1'b1;
                     else begin
                        stk_d[tos_idx] = nos;
                        stk_d[nos_idx] = tos;
                     end
                  end
                  OP_DROP: begin
                     if (!has1) unf_d = 1'b1;
                     else       depth_d = depth_q - DW'(1);
                  end
                  OP_CLEAR: begin
                     depth_d = '0;
                     ovf_d   = 1'b0;
                     unf_d   = 1'b0;
                     ill_d   = 1'b0;
                  end
                  default: ill_d = 1'b1;
               endcase
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Last multiplier bit: replace NOS/TOS with the truncated product.
            if (cnt_q == CW'(WIDTH-1)) begin
               stk_d[nos_idx] = acc_step;
               depth_d        = depth_q - DW'(1);
               done_d         = 1'b1;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      top_d = (depth_d == '0) ? '0 : stk_d[AW'(depth_d - DW'(1))];
   end

   // Control and visible-state registers with synchronous reset.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (Reset) begin
         state_q <= S_IDLE;
         depth_q <= '0;
         top_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         top_q   <= top_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stack storage and multiplier datapath, no reset needed.
   always_ff @(posedge Clock) begin
      // NOTE: the stack array is not reset; entries at or above depth are never observed.
      stk_q    <= stk_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

endmodule

// File: doc/rpn_engine.md
Name: rpn_engine

Overview:
- Parametrised reverse-Polish evaluation core; the next-generation arithmetic engine for the calculator.
- Replaces the fixed-width data stack and single-cycle ALU pairing with an internal stack of configurable width and depth.
- Adds a multi-cycle multiplier, stack-manipulation ops and sticky error reporting.
- Fed by the input interface through a valid/ack handshake; drives the display path with top-of-stack and depth.

Parameters:
WIDTH, 16, data word width in bits (>=4)
DEPTH, 8, stack entries (>=2)
DW, $clog2(DEPTH+1), width of depth output (derived, not overridable)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
in_valid  input  1  command present
in_ack  output  1  engine accepts a command this cycle
in_cmd  input  4  opcode: 0 NOP, 1 PUSH, 2 ADD, 3 SUB, 4 MUL, 5 DUP, 6 SWAP, 7 DROP, 8 CLEAR, 9-15 illegal
in_data  input  WIDTH  immediate value for PUSH
top_data  output  WIDTH  current top of stack; 0 when empty
depth  output  DW  number of valid entries, 0..DEPTH
done  output  1  one-cycle pulse when a command completes
err_ovf  output  1  sticky: push attempted with stack full
err_unf  output  1  sticky: operands missing
err_ill  output  1  sticky: illegal opcode

Behaviour:
- Clock and reset: one clock, Clock; Reset is synchronous and active-high.
- Reset values: state IDLE; depth=0; top_data=0; done=0; all err_* = 0; in_ack=1 in the cycle after Reset deasserts.
- Reset during MUL aborts the operation; the stack is emptied.
- Handshake: in_ack = (state==IDLE), combinational from state only. A command is accepted on a rising edge with in_valid && in_ack. in_cmd/in_data are sampled only on acceptance.
- States:
  - IDLE: single-cycle ops execute at the accept edge; done=1 in the following cycle; state stays IDLE.
  - MUL: entered on an accepted legal MUL; runs WIDTH cycles; in_ack=0 throughout.
  - MUL exit: at the end of cycle WIDTH, pops 2, pushes the product; done=1 in the next cycle (first IDLE cycle). MUL latency from accept to done is WIDTH+1 cycles.
- Operand rule: NOS = entry below TOS.
  - ADD: NOS+TOS.
  - SUB: NOS-TOS.
  - MUL: NOS*TOS, iterative shift-add, one multiplier bit per cycle.
  - All results truncated to WIDTH bits (mod 2^WIDTH), unsigned. No carry or overflow flag.
- Stack effects (depth delta):
  - PUSH +1; ADD/SUB/MUL -1; DUP +1; SWAP 0 (exchange TOS/NOS); DROP -1.
  - CLEAR: depth:=0, clears all err_*.
  - NOP: nothing, but still pulses done.
- Required operands: ADD, SUB, MUL, SWAP need depth>=2; DUP and DROP need depth>=1.
  - Violation: stack unchanged, err_unf:=1, done still pulses, MUL not entered.
- Overflow: PUSH or DUP with depth==DEPTH leaves the stack unchanged, sets err_ovf:=1, done pulses.
- Illegal opcode: stack unchanged, err_ill:=1, done pulses.
- Sticky errors: stay set until CLEAR or Reset; they do not block further commands.
- top_data/depth: registered; reflect the stack state after the last completed command. During MUL they show the pre-operation values.
- Entries above depth are don't-care and never visible on top_data.
- done is never asserted in two consecutive cycles during MUL. Back-to-back single-cycle commands may produce done on consecutive cycles.

Test Plan (WIDTH=8, DEPTH=4 unless noted):
- Reset, then PUSH 3, PUSH 5, ADD -> top_data=8, depth=1. done pulses 3 times, each one cycle after its accept. in_ack stays 1.
- PUSH 200, PUSH 100, ADD -> top_data=44 (wrap). Then PUSH 50, SUB -> top_data=250 (44-50 mod 256).
- PUSH 13, PUSH 11, MUL -> in_ack=0 for exactly 8 cycles. top_data/depth hold 11/2 during MUL. done asserts 9 cycles after accept with top_data=143, depth=1.
- PUSH 1,2,3,4, then PUSH 9 -> err_ovf=1, depth=4, top_data=4. DUP -> still 4, err_ovf stays 1. CLEAR -> depth=0, top_data=0, err_ovf=0.
- Empty stack, ADD -> err_unf=1, depth=0, done pulses, no MUL entry. Opcode 12 -> err_ill=1. PUSH 7, SWAP -> err_unf remains 1, top_data=7.
- PUSH 6, PUSH 7, MUL, assert Reset in MUL cycle 3 -> next cycle in_ack=1, depth=0, top_data=0, all errors 0. done is never asserted for the aborted MUL.
